// File: rtl/enable_lock_ctrl.sv
// -----------------------------------------------------------------------------
// enable_lock_ctrl
//
// Sequencer that owns the 4-bit control_signal code consumed by the
// enable/lock decoder (0001 = enable_all, 0010 = disabled, 0011 = lock_on).
// Two requesters issue commands through a valid/ready handshake. A
// round-robin arbiter picks one of them. A three-state FSM
// (DISABLED, ENABLED, LOCKED) then applies the command. LOCKED is sticky
// until reset. After every state change the arbiter is held off for
// SETTLE_CYCLES cycles, so downstream logic sees stable enables.
//
// Parameters
//   SETTLE_CYCLES   cycles req_ready stays low after a state change (0..255)
//
// Ports
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset
//   req_valid[1:0]  per-requester request valid
//   req_cmd[3:0]    per-requester command, bits [2i+1:2i]
//                   (01 ENABLE, 10 DISABLE, 11 LOCK, 00 illegal)
//   req_ready[1:0]  per-requester grant (combinational)
//   control_signal  registered decoder code
//   state[1:0]      registered FSM state (00 DISABLED, 01 ENABLED, 10 LOCKED)
//   resp_valid      one-cycle pulse per accepted command
//   resp_id         requester index of the response
//   resp_err        the accepted command was rejected
//   err_count[7:0]  saturating count of rejected commands
//                   (present only when ENABLE_LOCK_CTRL_ERR_CNT_EN is defined)
//
// Optional feature macro: ENABLE_LOCK_CTRL_ERR_CNT_EN
// -----------------------------------------------------------------------------
module enable_lock_ctrl #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    input  logic [3:0] req_cmd,
    output logic [1:0] req_ready,
    output logic [3:0] control_signal,
    output logic [1:0] state,
    output logic       resp_valid,
    output logic       resp_id,
    output logic       resp_err
`ifdef ENABLE_LOCK_CTRL_ERR_CNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    // The settle counter must be able to hold SETTLE_CYCLES. It keeps at
    // least one bit, so that SETTLE_CYCLES = 0 still elaborates.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);

    localparam logic [1:0] CMD_ENABLE  = 2'b01;
    localparam logic [1:0] CMD_DISABLE = 2'b10;
    localparam logic [1:0] CMD_LOCK    = 2'b11;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'b00,
        ST_ENABLED  = 2'b01,
        ST_LOCKED   = 2'b10
    } state_e;

    // Decoder code for each state. The unused state encoding maps to the
    // disabled code, so an illegal decoder code is never driven.
    function automatic logic [3:0] code_of(input state_e s);
        logic [3:0] code;
        case (s)
            ST_DISABLED: code = 4'b0010;
            ST_ENABLED:  code = 4'b0001;
            ST_LOCKED:   code = 4'b0011;
            default:     code = 4'b0010;
        endcase
        return code;
    endfunction

    state_e           state_r;
    logic [3:0]       ctrl_r;
    logic [CNT_W-1:0] settle_cnt_r;
    logic             pref_r;          // requester favoured when both are valid
    logic             resp_valid_r;
    logic             resp_id_r;
    logic             resp_err_r;

    logic       settled_s;
    logic [1:0] grant_s;
    logic       xfer_s;
    logic       xfer_id_s;
    logic [1:0] cmd_s;
    state_e     next_state_s;
    state_e     commit_state_s;
    logic       reject_s;
    logic       changed_s;

    assign settled_s = (settle_cnt_r == CNT_ZERO);

    // Round-robin grant: nothing while settling, otherwise the lone valid
    // requester, or the favoured one when both are valid.
    always_comb begin
        grant_s = 2'b00;
        if (!settled_s) begin
            grant_s = 2'b00;
        end else if (req_valid == 2'b11) begin
            grant_s = pref_r ? 2'b10 : 2'b01;
        end else begin
            grant_s = req_valid;
        end
    end

    assign xfer_s    = |(req_valid & grant_s);
    assign xfer_id_s = grant_s[1];
    assign cmd_s     = xfer_id_s ? req_cmd[3:2] : req_cmd[1:0];

    // Command decode. This block gives the proposed next state and tells
    // whether the command is rejected.
    always_comb begin
        next_state_s = state_r;
        reject_s     = 1'b0;
        case (state_r)
            ST_DISABLED, ST_ENABLED: begin
                case (cmd_s)
                    CMD_ENABLE:  next_state_s = ST_ENABLED;
                    CMD_DISABLE: next_state_s = ST_DISABLED;
                    CMD_LOCK:    next_state_s = ST_LOCKED;
                    default:     reject_s     = 1'b1;
                endcase
            end
            ST_LOCKED: begin
                reject_s = 1'b1;
            end
            default: begin
                // The unused encoding falls back to the safe disabled state.
                next_state_s = ST_DISABLED;
                reject_s     = 1'b1;
            end
        endcase
    end

    // Select the state that is committed at the next edge.
    always_comb begin
        commit_state_s = state_r;
        if (xfer_s) begin
            commit_state_s = next_state_s;
        end else begin
            commit_state_s = state_r;
        end
    end

    assign changed_s = xfer_s && (commit_state_s != state_r);

    // FSM, settle counter, arbitration pointer and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_DISABLED;
            ctrl_r       <= 4'b0010;
            settle_cnt_r <= CNT_ZERO;
            pref_r       <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_id_r    <= 1'b0;
            resp_err_r   <= 1'b0;
        end else begin
            state_r <= commit_state_s;
            ctrl_r  <= code_of(commit_state_s);

            if (changed_s) begin
                settle_cnt_r <= SETTLE_LOAD;
            end else if (!settled_s) begin
                settle_cnt_r <= settle_cnt_r - CNT_ONE;
            end else begin
                settle_cnt_r <= settle_cnt_r;
            end

            if (xfer_s) begin
                pref_r <= ~xfer_id_s;
            end else begin
                pref_r <= pref_r;
            end

            resp_valid_r <= xfer_s;
            resp_id_r    <= xfer_s & xfer_id_s;
            resp_err_r   <= xfer_s & reject_s;
        end
    end

`ifdef ENABLE_LOCK_CTRL_ERR_CNT_EN
    logic [7:0] err_count_r;

    // Saturating count of rejected commands. It updates on the same edge
    // as the response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count_r <= 8'd0;
        end else if (xfer_s && reject_s && (err_count_r != 8'd255)) begin
            err_count_r <= err_count_r + 8'd1;
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign err_count = err_count_r;
`endif

    assign req_ready      = grant_s;
    assign control_signal = ctrl_r;
    assign state          = state_r;
    assign resp_valid     = resp_valid_r;
    assign resp_id        = resp_id_r;
    assign resp_err       = resp_err_r;

endmodule

// File: tb/tb_enable_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_enable_lock_ctrl
//
// Self-checking bench for enable_lock_ctrl (SETTLE_CYCLES = 4).
// The bench runs in three phases:
//   - an idle sequence after reset;
//   - a directed vector table. It covers enable/settle, alternating grants,
//     illegal commands, locked rejection and reset during settle;
//   - random stimulus checked against a behavioural reference model.
// The model tracks the settle window as an absolute cycle number, and it
// takes the FSM transitions from a lookup table.
// -----------------------------------------------------------------------------
module tb_enable_lock_ctrl;

    localparam int SETTLE = 4;

    logic       clk_s = 1'b0;
    logic       rst_n_s;
    logic [1:0] req_valid_s;
    logic [3:0] req_cmd_s;
    logic [1:0] req_ready_s;
    logic [3:0] control_signal_s;
    logic [1:0] state_s;
    logic       resp_valid_s;
    logic       resp_id_s;
    logic       resp_err_s;
`ifdef ENABLE_LOCK_CTRL_ERR_CNT_EN
    logic [7:0] err_count_s;
`endif

    enable_lock_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk            (clk_s),
        .rst_n          (rst_n_s),
        .req_valid      (req_valid_s),
        .req_cmd        (req_cmd_s),
        .req_ready      (req_ready_s),
        .control_signal (control_signal_s),
        .state          (state_s),
        .resp_valid     (resp_valid_s),
        .resp_id        (resp_id_s),
        .resp_err       (resp_err_s)
`ifdef ENABLE_LOCK_CTRL_ERR_CNT_EN
        ,
        .err_count      (err_count_s)
`endif
    );

    // Free-running clock.
    always #5 clk_s = ~clk_s;

    int n_checks = 0;
    int n_errors = 0;

    // Compare one observed value with the value the bench expects.
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_state = 0;        // 0 DISABLED, 1 ENABLED, 2 LOCKED
    int m_pref = 0;
    int m_now = 0;          // edges seen so far
    int m_free_at = 0;      // first cycle in which grants are allowed again
    int m_rv = 0, m_rid = 0, m_rerr = 0, m_errc = 0;
    int next_tab[3][4];     // [state][cmd] -> next state, -1 = rejected
    int code_tab[3];

    function automatic logic [1:0] model_ready(input logic [1:0] v);
        if (m_now < m_free_at) return 2'b00;
        if (v == 2'b11) return (m_pref == 1) ? 2'b10 : 2'b01;
        return v;
    endfunction

    task automatic model_edge(input logic r, input logic [1:0] v, input logic [3:0] c);
        logic [1:0] g;
        int id, cmd, nxt;
        g = model_ready(v);
        m_now++;
        if (!r) begin
            m_state = 0; m_pref = 0; m_free_at = m_now;
            m_rv = 0; m_rid = 0; m_rerr = 0; m_errc = 0;
        end else begin
            m_rv = 0;
            if ((g & v) != 2'b00) begin
                id  = g[1] ? 1 : 0;
                cmd = int'((c >> (2 * id)) & 4'd3);
                nxt = next_tab[m_state][cmd];
                m_rv = 1; m_rid = id; m_pref = 1 - id;
                if (nxt < 0) begin
                    m_rerr = 1;
                    if (m_errc < 255) m_errc++;
                end else begin
                    m_rerr = 0;
                    if (nxt != m_state) begin
                        m_state   = nxt;
                        m_free_at = m_now + SETTLE;
                    end
                end
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    logic       cur_rst;
    logic [1:0] cur_v;
    logic [3:0] cur_c;

    // Drive inputs away from the active edge; req_ready is valid #1 later.
    task automatic drive(input logic r, input logic [1:0] v, input logic [3:0] c);
        @(negedge clk_s);
        rst_n_s = r; req_valid_s = v; req_cmd_s = c;
        cur_rst = r; cur_v = v; cur_c = c;
        #1;
    endtask

    // Take one active edge and advance the model; registered outputs are valid #1 later.
    task automatic edge_step();
        @(posedge clk_s);
        model_edge(cur_rst, cur_v, cur_c);
        #1;
    endtask

    task automatic check_err_count();
`ifdef ENABLE_LOCK_CTRL_ERR_CNT_EN
        check("err_count", 32'(err_count_s), 32'(m_errc));
`endif
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic       rst_n;
        logic [1:0] v;
        logic [3:0] c;
        logic [1:0] rdy;   // req_ready in the drive cycle
        logic [1:0] st;    // outputs after the edge
        logic [3:0] ctrl;
        logic       rv;
        logic       rid;
        logic       rerr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [1:0] v, input logic [3:0] c, input logic [1:0] rdy,
                       input logic [1:0] st, input logic [3:0] ctrl, input logic rv, input logic rid,
                       input logic rerr);
        vec_t e;
        e.rst_n = r; e.v = v; e.c = c; e.rdy = rdy; e.st = st; e.ctrl = ctrl;
        e.rv = rv; e.rid = rid; e.rerr = rerr;
        vecs.push_back(e);
    endtask

    initial begin
        next_tab[0] = '{-1, 1, 0, 2};
        next_tab[1] = '{-1, 1, 0, 2};
        next_tab[2] = '{-1, -1, -1, -1};
        code_tab    = '{2, 1, 3};

        // req0 ENABLE, then 4 settle cycles with both valid
        add(1'b1, 2'b01, 4'b0001, 2'b01, 2'b01, 4'b0001, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < SETTLE; i++)
            add(1'b1, 2'b11, 4'b0101, 2'b00, 2'b01, 4'b0001, 1'b0, 1'b0, 1'b0);
        // both valid; round robin picks req1 (DISABLE)
        add(1'b1, 2'b11, 4'b1011, 2'b10, 2'b00, 4'b0010, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < SETTLE; i++)
            add(1'b1, 2'b00, 4'b0000, 2'b00, 2'b00, 4'b0010, 1'b0, 1'b0, 1'b0);
        // both DISABLE from DISABLED: alternating grants, no settle gap
        add(1'b1, 2'b11, 4'b1010, 2'b01, 2'b00, 4'b0010, 1'b1, 1'b0, 1'b0);
        add(1'b1, 2'b11, 4'b1010, 2'b10, 2'b00, 4'b0010, 1'b1, 1'b1, 1'b0);
        add(1'b1, 2'b11, 4'b1010, 2'b01, 2'b00, 4'b0010, 1'b1, 1'b0, 1'b0);
        add(1'b1, 2'b11, 4'b1010, 2'b10, 2'b00, 4'b0010, 1'b1, 1'b1, 1'b0);
        // illegal command 00: rejected, no settle
        add(1'b1, 2'b01, 4'b0000, 2'b01, 2'b00, 4'b0010, 1'b1, 1'b0, 1'b1);
        // req1 ENABLE is granted immediately
        add(1'b1, 2'b10, 4'b0100, 2'b10, 2'b01, 4'b0001, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < SETTLE; i++)
            add(1'b1, 2'b00, 4'b0000, 2'b00, 2'b01, 4'b0001, 1'b0, 1'b0, 1'b0);
        // req0 LOCK
        add(1'b1, 2'b01, 4'b0011, 2'b01, 2'b10, 4'b0011, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < SETTLE; i++)
            add(1'b1, 2'b00, 4'b0000, 2'b00, 2'b10, 4'b0011, 1'b0, 1'b0, 1'b0);
        // LOCKED rejects everything and starts no settle window
        add(1'b1, 2'b10, 4'b0100, 2'b10, 2'b10, 4'b0011, 1'b1, 1'b1, 1'b1);
        add(1'b1, 2'b01, 4'b0010, 2'b01, 2'b10, 4'b0011, 1'b1, 1'b0, 1'b1);
        add(1'b1, 2'b11, 4'b1111, 2'b10, 2'b10, 4'b0011, 1'b1, 1'b1, 1'b1);
        // reset while a transfer is offered: the response is discarded
        add(1'b0, 2'b01, 4'b0001, 2'b01, 2'b00, 4'b0010, 1'b0, 1'b0, 1'b0);
        // LOCK, then reset in the middle of the settle window
        add(1'b1, 2'b01, 4'b0011, 2'b01, 2'b10, 4'b0011, 1'b1, 1'b0, 1'b0);
        add(1'b1, 2'b00, 4'b0000, 2'b00, 2'b10, 4'b0011, 1'b0, 1'b0, 1'b0);
        add(1'b0, 2'b10, 4'b0100, 2'b00, 2'b00, 4'b0010, 1'b0, 1'b0, 1'b0);
        add(1'b1, 2'b10, 4'b0100, 2'b10, 2'b01, 4'b0001, 1'b1, 1'b1, 1'b0);
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n_s = 1'b0; req_valid_s = 2'b00; req_cmd_s = 4'b0000;
        #0;

        // reset for two edges
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 2'b00, 4'b0000);
            edge_step();
        end
        check("reset_state", 32'(state_s), 32'd0);
        check("reset_ctrl", 32'(control_signal_s), 32'h2);
        check("reset_resp_valid", 32'(resp_valid_s), 32'd0);
        check_err_count();

        // idle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'b00, 4'b0000);
            check("idle_ready", 32'(req_ready_s), 32'd0);
            edge_step();
            check("idle_state", 32'(state_s), 32'd0);
            check("idle_ctrl", 32'(control_signal_s), 32'h2);
            check("idle_resp_valid", 32'(resp_valid_s), 32'd0);
        end

        // directed table
        foreach (vecs[k]) begin
            drive(vecs[k].rst_n, vecs[k].v, vecs[k].c);
            check($sformatf("vec%0d_ready", k), 32'(req_ready_s), 32'(vecs[k].rdy));
            edge_step();
            check($sformatf("vec%0d_state", k), 32'(state_s), 32'(vecs[k].st));
            check($sformatf("vec%0d_ctrl", k), 32'(control_signal_s), 32'(vecs[k].ctrl));
            check($sformatf("vec%0d_resp_valid", k), 32'(resp_valid_s), 32'(vecs[k].rv));
            if (vecs[k].rv) begin
                check($sformatf("vec%0d_resp_id", k), 32'(resp_id_s), 32'(vecs[k].rid));
                check($sformatf("vec%0d_resp_err", k), 32'(resp_err_s), 32'(vecs[k].rerr));
            end
            check_err_count();
        end

        // randomized stimulus against the reference model
        drive(1'b0, 2'b00, 4'b0000);
        edge_step();
        for (int i = 0; i < 600; i++) begin
            logic       r;
            logic [1:0] v;
            logic [3:0] c;
            r = ($urandom_range(0, 39) != 0);
            v = 2'($urandom_range(0, 3));
            c = 4'($urandom_range(0, 15));
            drive(r, v, c);
            check("rand_ready", 32'(req_ready_s), 32'(model_ready(v)));
            edge_step();
            check("rand_state", 32'(state_s), 32'(m_state));
            check("rand_ctrl", 32'(control_signal_s), 32'(code_tab[m_state]));
            check("rand_resp_valid", 32'(resp_valid_s), 32'(m_rv));
            if (m_rv != 0) begin
                check("rand_resp_id", 32'(resp_id_s), 32'(m_rid));
                check("rand_resp_err", 32'(resp_err_s), 32'(m_rerr));
            end
            check_err_count();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
